id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register that feeds the ALU: captures decoded operands, the 4-bit ALU opcode and
//  the destination register, then resolves RAW hazards on the register operands (bypass from EX/MEM
//  and MEM/WB, load-use stall) to drive a_o/b_o/alu_op_o straight into the ALU.
//  Single-entry stage with valid/ready handshake on both sides, plus flush for branch redirect.
// PARAMETERS
//  XLEN      32  operand/data width
//  REG_AW     5  register index width
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_ni         in   1      async reset, active low
//  flush_i        in   1      kill held and incoming instruction (branch/jump redirect)
//  in_valid_i     in   1      decode offers instruction
//  in_ready_o     out  1      stage accepts this cycle
//  pc_i           in   XLEN   instruction PC
//  rs1_idx_i      in   REG_AW source 1 index;  rs1_data_i  in XLEN  regfile read data
//  rs2_idx_i      in   REG_AW source 2 index;  rs2_data_i  in XLEN  regfile read data
//  imm_i          in   XLEN   sign-extended immediate
//  a_sel_i        in   1      0: A=rs1, 1: A=PC
//  b_sel_i        in   1      0: B=rs2, 1: B=imm
//  alu_op_i       in   4      0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLL,0110 SRL,0111 SRA,1000 SLT,1001 SLTU
//  rd_idx_i       in   REG_AW destination; rd_we_i in 1 writes rd
//  exm_we_i, exm_rd_i, exm_data_i, exm_is_load_i   in  1/REG_AW/XLEN/1  EX/MEM bypass source
//  wb_we_i,  wb_rd_i,  wb_data_i                   in  1/REG_AW/XLEN    MEM/WB bypass source
//  out_valid_o    out  1      operands valid for ALU
//  out_ready_i    in   1      EX consumes
//  a_o, b_o       out  XLEN   ALU operands;  alu_op_o out 4;  rd_idx_o out REG_AW;  rd_we_o out 1
//  stall_o        out  1      load-use hazard active
// BEHAVIOUR
//  - State: valid_q (EMPTY=0/FULL=1). Reset: valid_q=0, all payload regs 0; out_valid_o=0, stall_o=0,
//    a_o=b_o=0, alu_op_o=0000, rd_we_o=0, in_ready_o=1.
//  - fire_out = out_valid_o & out_ready_i. in_ready_o = ~valid_q | fire_out (combinational).
//  - Capture on in_valid_i & in_ready_o & ~flush_i; latency 1 cycle from accept to out_valid_o.
//  - flush_i: valid_q<=0 next edge, incoming beat dropped, regardless of handshake; outputs keep stale data.
//  - Operand source per rsN (registered idx/data): idx==0 -> 0 (never bypassed);
//    else exm_we_i & exm_rd_i==idx -> exm_data_i; else wb_we_i & wb_rd_i==idx -> wb_data_i; else stored data.
//    EX/MEM has priority over MEM/WB. Bypass mux is combinational on outputs.
//  - a_o = a_sel ? pc_q : opA;  b_o = b_sel ? imm_q : opB. Unused operand not checked for hazards.
//  - Load-use: valid_q & exm_is_load_i & exm_we_i & exm_rd_i!=0 & exm_rd_i matches a used rs -> stall_o=1,
//    out_valid_o=0 (holds entry); out_valid_o = valid_q & ~stall_o otherwise.
//  - Hold refresh: while valid_q & ~fire_out, if wb_we_i & wb_rd_i==rsN_idx_q (!=0), rsN_data_q<=wb_data_i,
//    so values written back during a stall are not lost.
//  - Simultaneous fire_out and accept: new entry replaces old, valid_q stays 1 (full throughput).
//  - rd_we_o forced 0 when rd_idx_q==0.
// CONFIGURATION
//  ID_EX_FWD_EN defined: bypass network and load-use stall as above.
//  Not defined: operands taken from stored regfile data only (with hold refresh), stall_o tied 0;
//  hazards handled by software/nops.
// TESTING
//  1 Reset low mid-transfer -> out_valid_o=0, in_ready_o=1, a_o=b_o=0 immediately (async).
//  2 ADD x3,x1,x2 with rs1_data=5,rs2_data=7, no bypass -> next cycle out_valid_o=1,a_o=5,b_o=7,alu_op_o=0000.
//  3 rs1=x1, exm_we=1 rd=1 data=0x10 and wb rd=1 data=0x20 -> a_o=0x10 (EX/MEM priority); rs1=x0 -> a_o=0.
//  4 rs2=x4, exm_is_load=1 rd=4 -> stall_o=1,out_valid_o=0,in_ready_o=0; next cycle load moves to WB
//    (wb rd=4 data=0x99) -> b_o=0x99, out_valid_o=1.
//  5 out_ready_i=0 for 3 cycles, wb writes rs1 idx with 0xAB then bypass drops -> a_o=0xAB on release.
//  6 flush_i with in_valid_i=1 and valid_q=1 -> next cycle out_valid_o=0, incoming dropped.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register feeding the ALU. Holds one decoded instruction
// (operands, immediate, PC, ALU opcode, destination) behind a valid/ready
// handshake on both sides. On the output side it resolves register
// read-after-write hazards before driving a_o/b_o into the ALU.
//
// Configuration macro: ID_EX_FWD_EN
//   defined   : EX/MEM and MEM/WB bypass network plus load-use stall.
//   undefined : operands come from the stored register-file data only
//               (still refreshed by write-back while held); stall_o is 0.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   flush_i                       kill the held and the incoming instruction
//   in_valid_i / in_ready_o       decode-side handshake
//   pc_i, imm_i                   instruction PC and sign-extended immediate
//   rs1_idx_i/rs1_data_i          source 1 index and register-file data
//   rs2_idx_i/rs2_data_i          source 2 index and register-file data
//   a_sel_i / b_sel_i             A: 0=rs1 1=PC ; B: 0=rs2 1=imm
//   alu_op_i, rd_idx_i, rd_we_i   ALU opcode, destination, write enable
//   exm_*                         EX/MEM bypass source (incl. load flag)
//   wb_*                          MEM/WB bypass source
//   out_valid_o / out_ready_i     EX-side handshake
//   a_o, b_o, alu_op_o            ALU operands and opcode
//   rd_idx_o, rd_we_o             destination (write enable masked for x0)
//   stall_o                       load-use hazard is holding the entry
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [REG_AW-1:0] rs1_idx_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [REG_AW-1:0] rs2_idx_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              a_sel_i,
    input  logic              b_sel_i,
    input  logic [3:0]        alu_op_i,
    input  logic [REG_AW-1:0] rd_idx_i,
    input  logic              rd_we_i,
    input  logic              exm_we_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [XLEN-1:0]   exm_data_i,
    input  logic              exm_is_load_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic [3:0]        alu_op_o,
    output logic [REG_AW-1:0] rd_idx_o,
    output logic              rd_we_o,
    output logic              stall_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [XLEN-1:0]   XZERO    = {XLEN{1'b0}};

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs1_idx_q, rs1_idx_d, rs2_idx_q, rs2_idx_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic              a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [REG_AW-1:0] rd_idx_q, rd_idx_d;
    logic              rd_we_q, rd_we_d;

    logic              fire_out_s, accept_s, stall_s;
    logic [XLEN-1:0]   op_a_s, op_b_s;

`ifdef ID_EX_FWD_EN
    // Youngest producer wins; x0 is hardwired zero and never bypassed.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [REG_AW-1:0] idx,
        input logic [XLEN-1:0]   stored,
        input logic              exm_we,
        input logic [REG_AW-1:0] exm_rd,
        input logic [XLEN-1:0]   exm_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        logic [XLEN-1:0] res;
        if (idx == REG_ZERO) begin
            res = XZERO;
        end else if (exm_we && (exm_rd == idx)) begin
            res = exm_data;
        end else if (wb_we && (wb_rd == idx)) begin
            res = wb_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Operand selection through the bypass network.
    always_comb begin
        op_a_s = pick_operand(rs1_idx_q, rs1_data_q, exm_we_i, exm_rd_i, exm_data_i,
                              wb_we_i, wb_rd_i, wb_data_i);
        op_b_s = pick_operand(rs2_idx_q, rs2_data_q, exm_we_i, exm_rd_i, exm_data_i,
                              wb_we_i, wb_rd_i, wb_data_i);
    end

    // Load-use hazard: a load in EX/MEM targets a source the ALU actually uses.
    always_comb begin
        stall_s = valid_q & exm_is_load_i & exm_we_i & (exm_rd_i != REG_ZERO) &
                  ((~a_sel_q & (exm_rd_i == rs1_idx_q)) |
                   (~b_sel_q & (exm_rd_i == rs2_idx_q)));
    end
`else
    logic unused_fwd_s;

    // No bypass: stored data only, x0 still reads as zero.
    always_comb begin
        op_a_s = (rs1_idx_q == REG_ZERO) ? XZERO : rs1_data_q;
        op_b_s = (rs2_idx_q == REG_ZERO) ? XZERO : rs2_data_q;
    end

    // Hazards are resolved by software in this build; EX/MEM inputs are ignored.
    always_comb begin
        stall_s      = 1'b0;
        unused_fwd_s = ^{exm_we_i, exm_rd_i, exm_data_i, exm_is_load_i};
    end
`endif

    // Handshake glue; in_ready allows a new beat while the held one leaves.
    always_comb begin
        out_valid_o = valid_q & ~stall_s;
        fire_out_s  = out_valid_o & out_ready_i;
        in_ready_o  = ~valid_q | fire_out_s;
        accept_s    = in_valid_i & in_ready_o & ~flush_i;
    end

    // Next-state for occupancy and payload, including write-back refresh while held.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_idx_d  = rs1_idx_q;
        rs1_data_d = rs1_data_q;
        rs2_idx_d  = rs2_idx_q;
        rs2_data_d = rs2_data_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        alu_op_d   = alu_op_q;
        rd_idx_d   = rd_idx_q;
        rd_we_d    = rd_we_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
        end else if (fire_out_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (accept_s) begin
            pc_d       = pc_i;
            imm_d      = imm_i;
            rs1_idx_d  = rs1_idx_i;
            rs1_data_d = rs1_data_i;
            rs2_idx_d  = rs2_idx_i;
            rs2_data_d = rs2_data_i;
            a_sel_d    = a_sel_i;
            b_sel_d    = b_sel_i;
            alu_op_d   = alu_op_i;
            rd_idx_d   = rd_idx_i;
            rd_we_d    = rd_we_i;
        end else if (valid_q && !fire_out_s) begin
            // A held entry would otherwise miss a write-back that retires while it waits.
            if (wb_we_i && (wb_rd_i == rs1_idx_q) && (rs1_idx_q != REG_ZERO)) begin
                rs1_data_d = wb_data_i;
            end else begin
                rs1_data_d = rs1_data_q;
            end
            if (wb_we_i && (wb_rd_i == rs2_idx_q) && (rs2_idx_q != REG_ZERO)) begin
                rs2_data_d = wb_data_i;
            end else begin
                rs2_data_d = rs2_data_q;
            end
        end else begin
            rs1_data_d = rs1_data_q;
            rs2_data_d = rs2_data_q;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            pc_q       <= XZERO;
            imm_q      <= XZERO;
            rs1_idx_q  <= REG_ZERO;
            rs1_data_q <= XZERO;
            rs2_idx_q  <= REG_ZERO;
            rs2_data_q <= XZERO;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            alu_op_q   <= 4'b0000;
            rd_idx_q   <= REG_ZERO;
            rd_we_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_idx_q  <= rs1_idx_d;
            rs1_data_q <= rs1_data_d;
            rs2_idx_q  <= rs2_idx_d;
            rs2_data_q <= rs2_data_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            alu_op_q   <= alu_op_d;
            rd_idx_q   <= rd_idx_d;
            rd_we_q    <= rd_we_d;
        end
    end

    // ALU-facing outputs; writes to x0 are suppressed here.
    always_comb begin
        a_o      = a_sel_q ? pc_q : op_a_s;
        b_o      = b_sel_q ? imm_q : op_b_s;
        alu_op_o = alu_op_q;
        rd_idx_o = rd_idx_q;
        rd_we_o  = rd_we_q & (rd_idx_q != REG_ZERO);
        stall_o  = stall_s;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ALU beats are queued when a beat
// is offered that will be accepted and compared when EX consumes it.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i, rst_ni, flush_i, in_valid_i, in_ready_o;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_idx_i, rs2_idx_i, rd_idx_i;
    logic        a_sel_i, b_sel_i, rd_we_i;
    logic [3:0]  alu_op_i;
    logic        exm_we_i, exm_is_load_i, wb_we_i;
    logic [4:0]  exm_rd_i, wb_rd_i;
    logic [31:0] exm_data_i, wb_data_i;
    logic        out_valid_o, out_ready_i, rd_we_o, stall_o;
    logic [31:0] a_o, b_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  rd_idx_o;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .rs1_idx_i(rs1_idx_i), .rs1_data_i(rs1_data_i),
        .rs2_idx_i(rs2_idx_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .a_sel_i(a_sel_i), .b_sel_i(b_sel_i), .alu_op_i(alu_op_i),
        .rd_idx_i(rd_idx_i), .rd_we_i(rd_we_i),
        .exm_we_i(exm_we_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
        .exm_is_load_i(exm_is_load_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .a_o(a_o), .b_o(b_o), .alu_op_o(alu_op_o),
        .rd_idx_o(rd_idx_o), .rd_we_o(rd_we_o), .stall_o(stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks out_valid_o; when EX consumes this cycle, pops and compares the payload.
    task automatic compare_out(input string tag, input logic exp_valid);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, out_valid_o}, {31'd0, exp_valid});
        if (exp_valid && out_ready_i) begin
            chk({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_a"},  a_o, e.a);
                chk({tag, "_b"},  b_o, e.b);
                chk({tag, "_op"}, {28'd0, alu_op_o}, {28'd0, e.op});
                chk({tag, "_rd"}, {27'd0, rd_idx_o}, {27'd0, e.rd});
                chk({tag, "_we"}, {31'd0, rd_we_o},  {31'd0, e.we});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_bypass();
        exm_we_i = 1'b0; exm_rd_i = 5'd0; exm_data_i = 32'd0; exm_is_load_i = 1'b0;
        wb_we_i  = 1'b0; wb_rd_i  = 5'd0; wb_data_i  = 32'd0;
    endtask

    task automatic drive_beat(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                              input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                              input logic as, input logic bs, input logic [3:0] op,
                              input logic [4:0] rd, input logic we);
        in_valid_i = 1'b1; pc_i = pc; rs1_idx_i = r1; rs1_data_i = d1;
        rs2_idx_i = r2; rs2_data_i = d2; imm_i = imm; a_sel_i = as; b_sel_i = bs;
        alu_op_i = op; rd_idx_i = rd; rd_we_i = we;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] rd, input logic we);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rd; e.we = we;
        sb_q.push_back(e);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        drive_beat(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
        in_valid_i = 1'b0;
        clr_bypass();
        #3;
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_o},  32'd1);
        chk("rst_a", a_o, 32'd0);
        chk("rst_b", b_o, 32'd0);
        chk("rst_op", {28'd0, alu_op_o}, 32'd0);
        chk("rst_we", {31'd0, rd_we_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // ADD x3,x1,x2 with no bypass
        tick();
        drive_beat(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0000, 5'd3, 1'b1);
        push(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1);
        #1 chk("add_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        #1 compare_out("add", 1'b1);

        // EX/MEM beats MEM/WB on rs1; rs2=x0 reads zero whatever the regfile says
        tick();
        drive_beat(32'h104, 5'd1, 32'h111, 5'd0, 32'h222, 32'd0, 1'b0, 1'b0, 4'b0001, 5'd5, 1'b1);
        push(FWD ? 32'h10 : 32'h111, 32'd0, 4'b0001, 5'd5, 1'b1);
        tick();
        in_valid_i = 1'b0;
        exm_we_i = 1'b1; exm_rd_i = 5'd1; exm_data_i = 32'h10;
        wb_we_i  = 1'b1; wb_rd_i  = 5'd1; wb_data_i  = 32'h20;
        #1 compare_out("prio", 1'b1);

        // Load-use on rs2=x4 (A uses PC, so rs1 is ignored)
        tick();
        clr_bypass();
        drive_beat(32'h1000, 5'd2, 32'd3, 5'd4, 32'h44, 32'd0, 1'b1, 1'b0, 4'b0010, 5'd6, 1'b1);
        push(32'h1000, FWD ? 32'h99 : 32'h44, 4'b0010, 5'd6, 1'b1);
        tick();
        in_valid_i = 1'b0;
        exm_we_i = 1'b1; exm_rd_i = 5'd4; exm_data_i = 32'hDEAD; exm_is_load_i = 1'b1;
        #1;
        chk("lu_stall", {31'd0, stall_o}, {31'd0, FWD});
        chk("lu_in_ready", {31'd0, in_ready_o}, {31'd0, ~FWD});
        compare_out("lu_hold", ~FWD);
        tick();
        clr_bypass();
        wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'h99;
        #1;
        chk("lu_release_stall", {31'd0, stall_o}, 32'd0);
        compare_out("lu_release", FWD);

        // Held 3 cycles; write-back of rs1 arrives then disappears
        tick();
        clr_bypass();
        drive_beat(32'h200, 5'd7, 32'h70, 5'd8, 32'h80, 32'hFFFF_FFF0, 1'b0, 1'b1, 4'b0011, 5'd9, 1'b1);
        push(32'hAB, 32'hFFFF_FFF0, 4'b0011, 5'd9, 1'b1);
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hAB;
        #1;
        compare_out("hold1", 1'b1);
        chk("hold1_a", a_o, FWD ? 32'hAB : 32'h70);
        tick();
        clr_bypass();
        #1;
        compare_out("hold2", 1'b1);
        chk("hold2_a", a_o, 32'hAB);
        tick();
        drive_beat(32'h300, 5'd1, 32'd1, 5'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b1);
        #1;
        chk("hold3_in_ready", {31'd0, in_ready_o}, 32'd0);
        compare_out("hold3", 1'b1);
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1 compare_out("hold_release", 1'b1);

        // Flush kills held entry and the incoming beat
        tick();
        out_ready_i = 1'b0;
        drive_beat(32'h400, 5'd3, 32'h3, 5'd4, 32'h4, 32'd0, 1'b0, 1'b0, 4'b0100, 5'd2, 1'b1);
        tick();
        drive_beat(32'h404, 5'd5, 32'h5, 5'd6, 32'h6, 32'd0, 1'b0, 1'b0, 4'b0101, 5'd3, 1'b1);
        flush_i = 1'b1;
        #1 compare_out("pre_flush", 1'b1);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1;
        compare_out("flush", 1'b0);
        chk("flush_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Back-to-back beats; rd=x0 masks rd_we_o
        out_ready_i = 1'b1;
        tick();
        drive_beat(32'h500, 5'd10, 32'hA0, 5'd11, 32'h0B, 32'd0, 1'b0, 1'b0, 4'b1001, 5'd0, 1'b1);
        push(32'hA0, 32'h0B, 4'b1001, 5'd0, 1'b0);
        tick();
        drive_beat(32'h2000, 5'd12, 32'hC, 5'd13, 32'hD, 32'h4, 1'b1, 1'b1, 4'b0000, 5'd1, 1'b1);
        push(32'h2000, 32'h4, 4'b0000, 5'd1, 1'b1);
        #1;
        chk("b2b_in_ready", {31'd0, in_ready_o}, 32'd1);
        compare_out("b2b_first", 1'b1);
        tick();
        in_valid_i = 1'b0;
        #1 compare_out("b2b_second", 1'b1);
        tick();
        #1 compare_out("b2b_empty", 1'b0);

        // Asynchronous reset while an entry is held
        tick();
        out_ready_i = 1'b0;
        drive_beat(32'h600, 5'd14, 32'hE, 5'd15, 32'hF, 32'd0, 1'b0, 1'b0, 4'b0110, 5'd4, 1'b1);
        tick();
        in_valid_i = 1'b0;
        #1 compare_out("pre_rst", 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_ready", {31'd0, in_ready_o},  32'd1);
        chk("arst_a", a_o, 32'd0);
        chk("arst_b", b_o, 32'd0);
        chk("arst_we", {31'd0, rd_we_o}, 32'd0);
        chk("arst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
